// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SLICE-bit lookahead group per stage,
// carry registered between stages. Define PIPE_ADD_OVF_EN to add the registered ovf output.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef PIPE_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NSTAGE = (SLICE > 0) ? WIDTH / SLICE : 1;

    if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_param_check
        $error("pipelined_cla_adder: WIDTH must be a nonzero multiple of SLICE");
    end

    logic             en;
    logic [WIDTH-1:0] b_prep;
    logic             c_prep;

    // Global stall: every stage advances together or not at all.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign b_prep   = sub ? ~b : b;
    assign c_prep   = sub | c_in;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        // Operand bits not yet resolved when the transaction enters stage k.
        localparam int IW = WIDTH - k * SLICE;

        logic [IW-1:0]          a_in;
        logic [IW-1:0]          b_in;
        logic                   cy_in;
        logic                   v_in;
        logic [SLICE-1:0]       g;
        logic [SLICE-1:0]       p;
        logic [SLICE-1:0]       s_slice;
        logic [SLICE:0]         c;
        logic [(k+1)*SLICE-1:0] s_nxt;
        logic                   v_q;
        logic                   c_q;
        logic [(k+1)*SLICE-1:0] s_q;

        if (k == 0) begin : g_src
            assign a_in  = a;
            assign b_in  = b_prep;
            assign cy_in = c_prep;
            assign v_in  = in_valid;
            assign s_nxt = s_slice;
        end else begin : g_src
            assign a_in  = g_stage[k-1].g_fwd.a_q;
            assign b_in  = g_stage[k-1].g_fwd.b_q;
            assign cy_in = g_stage[k-1].c_q;
            assign v_in  = g_stage[k-1].v_q;
            assign s_nxt = {s_slice, g_stage[k-1].s_q};
        end

        always_comb begin
            g    = a_in[SLICE-1:0] & b_in[SLICE-1:0];
            p    = a_in[SLICE-1:0] ^ b_in[SLICE-1:0];
            c    = '0;
            c[0] = cy_in;
            for (int i = 0; i < SLICE; i++) begin
                c[i+1] = g[i] | (p[i] & c[i]);
            end
            s_slice = p ^ c[SLICE-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_in;
                c_q <= c[SLICE];
                s_q <= s_nxt;
            end
        end

        // Upper operand slices ride along until their own stage consumes them.
        if (k < NSTAGE - 1) begin : g_fwd
            logic [IW-SLICE-1:0] a_q;
            logic [IW-SLICE-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_in[IW-1:SLICE];
                    b_q <= b_in[IW-1:SLICE];
                end
            end
        end

`ifdef PIPE_ADD_OVF_EN
        if (k == NSTAGE - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= c[SLICE] ^ c[SLICE-1];
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[NSTAGE-1].v_q;
    assign sum       = g_stage[NSTAGE-1].s_q;
    assign c_out     = g_stage[NSTAGE-1].c_q;
`ifdef PIPE_ADD_OVF_EN
    assign ovf       = g_stage[NSTAGE-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder (WIDTH=16, SLICE=4): directed literal checks plus
// randomized traffic against a stallable fixed-latency arithmetic model.
module tb_pipelined_cla_adder;
    localparam int W   = 16;
    localparam int SL  = 4;
    localparam int NST = W / SL;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int n_cmp = 0;
    int n_bad = 0;

    pipelined_cla_adder #(.WIDTH(W), .SLICE(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out)
`ifdef PIPE_ADD_OVF_EN
        , .ovf(ovf)
`endif
    );

`ifndef PIPE_ADD_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain modulo arithmetic, with a delay line of NST slots that only
    // advances when the model's own output is empty or accepted.
    typedef struct packed {
        logic         v;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } slot_t;

    function automatic slot_t calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        slot_t        r;
        logic [W:0]   t;
        logic [W-1:0] yy;
        logic         cc;
        yy  = sb ? ~y : y;
        cc  = sb ? 1'b1 : ci;
        t   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
        r.v = 1'b1;
        r.s = t[W-1:0];
        r.c = t[W];
        r.o = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
        return r;
    endfunction

    slot_t pipe [NST];
    logic  chk_on = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NST; i++) pipe[i] <= '0;
        end else if (!pipe[NST-1].v || out_ready) begin
            for (int i = NST - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= in_valid ? calc(a, b, c_in, sub) : '0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            chk("model_out_valid", {31'd0, out_valid}, {31'd0, pipe[NST-1].v});
            chk("model_in_ready", {31'd0, in_ready}, {31'd0, (!pipe[NST-1].v || out_ready)});
            if (pipe[NST-1].v) begin
                chk("model_sum", {16'd0, sum}, {16'd0, pipe[NST-1].s});
                chk("model_c_out", {31'd0, c_out}, {31'd0, pipe[NST-1].c});
`ifdef PIPE_ADD_OVF_EN
                chk("model_ovf", {31'd0, ovf}, {31'd0, pipe[NST-1].o});
`endif
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic ts);
        int w = 0;
        in_valid = 1'b1; a = ta; b = tb_; c_in = tc; sub = ts;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_out(input string nm, input logic [W-1:0] es, input logic ec);
        int w = 0;
        @(negedge clk);
        while (!(out_valid && out_ready) && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: no result, required sum %h", nm, es);
        end else begin
            chk({nm, "_sum"}, {16'd0, sum}, {16'd0, es});
            chk({nm, "_c_out"}, {31'd0, c_out}, {31'd0, ec});
        end
    endtask

    function automatic logic [W-1:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'hFFFF;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int  seen;
        bit  done;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_c_out", {31'd0, c_out}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst_n  = 1'b1;
        chk_on = 1'b1;
        tick();

        // Full carry ripple and latency.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        repeat (NST - 1) begin
            @(negedge clk);
            chk("lat_early_valid", {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("wrap_sum", {16'd0, sum}, 32'h0000);
        chk("wrap_c_out", {31'd0, c_out}, 32'd1);
        tick();

        // Subtraction, c_in ignored.
        send(16'h0005, 16'h0007, 1'b1, 1'b1);
        send(16'h0007, 16'h0005, 1'b0, 1'b1);
        wait_out("sub_neg", 16'hFFFE, 1'b0);
        wait_out("sub_pos", 16'h0002, 1'b1);
        tick();

        // Backpressure for 3 cycles after the first result appears.
        out_ready = 1'b0;
        send(16'h0001, 16'h0001, 1'b0, 1'b0);
        send(16'h0002, 16'h0002, 1'b0, 1'b0);
        send(16'h0003, 16'h0003, 1'b0, 1'b0);
        send(16'h0004, 16'h0004, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_sum", {16'd0, sum}, 32'h0002);
            tick();
        end
        out_ready = 1'b1;
        wait_out("bp0", 16'h0002, 1'b0);
        wait_out("bp1", 16'h0004, 1'b0);
        wait_out("bp2", 16'h0006, 1'b0);
        wait_out("bp3", 16'h0008, 1'b0);
        tick();

        // Bubble between two transactions.
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        tick();
        send(16'h1000, 16'h1000, 1'b0, 1'b0);
        wait_out("bub0", 16'h0100, 1'b0);
        @(negedge clk);
        chk("bub_gap_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("bub1_valid", {31'd0, out_valid}, 32'd1);
        chk("bub1_sum", {16'd0, sum}, 32'h2000);
        tick();

`ifdef PIPE_ADD_OVF_EN
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h1234, 16'h0001, 1'b0, 1'b0);
        wait_out("ovf0", 16'h8000, 1'b0);
        chk("ovf0_ovf", {31'd0, ovf}, 32'd1);
        wait_out("ovf1", 16'h7FFF, 1'b1);
        chk("ovf1_ovf", {31'd0, ovf}, 32'd1);
        wait_out("ovf2", 16'h1235, 1'b0);
        chk("ovf2_ovf", {31'd0, ovf}, 32'd0);
        tick();
`endif

        // Reset while two transactions are in flight.
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b0, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sum", {16'd0, sum}, 32'd0);
        chk("midrst_c_out", {31'd0, c_out}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_stale", seen, 32'd0);
        tick();

        // Randomized traffic with random backpressure.
        done = 1'b0;
        fork
            begin
                repeat (400) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    else send(rnd16(), rnd16(), 1'($urandom), 1'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (NST + 4) tick();

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
